// File: rtl/lzc_norm_pipe.sv
// Two-stage pipelined leading-zero counter and left normaliser for the FPU add/sub path.
// Optional sideband tag carried alongside each beat when LZN_TAG_EN is defined.
module lzc_norm_pipe #(
   parameter int WIDTH   = 27,
   parameter int MSB_IDX = 25,
   parameter int GROUP   = 4,
   parameter int CNT_W   = $clog2(MSB_IDX + 2),
   parameter int TAG_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_cnt,
   output logic             out_zero,
   output logic [WIDTH-1:0] out_norm
`ifdef LZN_TAG_EN
   ,
   input  logic [TAG_W-1:0] tag_in,
   output logic [TAG_W-1:0] tag_out
`endif
);

   localparam int unsigned NB  = MSB_IDX + 1;
   localparam int unsigned NG  = (NB + GROUP - 1) / GROUP;
   localparam int unsigned PW  = NG * GROUP;
   localparam int unsigned PAD = PW - NB;
   localparam int unsigned LW  = (GROUP > 1) ? $clog2(GROUP) : 1;

   if (MSB_IDX < 0 || MSB_IDX >= WIDTH) begin : g_bad_msb
      $error("MSB_IDX must lie within 0..WIDTH-1");
   end
   if (GROUP < 1) begin : g_bad_group
      $error("GROUP must be at least 1");
   end
   if (TAG_W < 1) begin : g_bad_tag
      $error("TAG_W must be at least 1");
   end

   logic                   s1_valid;
   logic [WIDTH-1:0]       s1_data;
   logic [NG-1:0]          s1_nz;
   logic [NG-1:0][LW-1:0]  s1_lcnt;
   logic                   s2_valid;
   logic                   adv1;
   logic                   adv2;

   logic [PW-1:0]          padded;
   logic [NG-1:0]          nz_c;
   logic [NG-1:0][LW-1:0]  lcnt_c;
   logic [CNT_W-1:0]       cnt_c;
   logic                   zero_c;
   logic [WIDTH-1:0]       norm_c;

   assign adv2      = !s2_valid || out_ready;
   assign adv1      = !s1_valid || adv2;
   assign in_ready  = adv1;
   assign out_valid = s2_valid;

   // Searched field is left-aligned into whole groups; the short tail group is zero padded at the LSB end.
   always_comb begin
      padded = '0;
      nz_c   = '0;
      lcnt_c = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         padded[i + PAD] = in_data[i];
      end
      for (int unsigned g = 0; g < NG; g++) begin
         for (int unsigned j = 0; j < GROUP; j++) begin
            if (padded[PW - 1 - g * GROUP - j] && !nz_c[g]) begin
               nz_c[g]   = 1'b1;
               lcnt_c[g] = LW'(j);
            end
         end
      end
   end

   always_comb begin
      cnt_c  = CNT_W'(NB);
      zero_c = 1'b1;
      for (int unsigned g = 0; g < NG; g++) begin
         if (zero_c && s1_nz[g]) begin
            zero_c = 1'b0;
            cnt_c  = CNT_W'(g * GROUP) + CNT_W'(s1_lcnt[g]);
         end
      end
      norm_c = s1_data << cnt_c;
   end

   // Data registers load only with a valid beat so outputs hold while empty or stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_nz    <= '0;
         s1_lcnt  <= '0;
         s2_valid <= 1'b0;
         out_cnt  <= '0;
         out_zero <= 1'b0;
         out_norm <= '0;
      end else begin
         if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_data <= in_data;
               s1_nz   <= nz_c;
               s1_lcnt <= lcnt_c;
            end
         end
         if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               out_cnt  <= cnt_c;
               out_zero <= zero_c;
               out_norm <= norm_c;
            end
         end
      end
   end

`ifdef LZN_TAG_EN
   logic [TAG_W-1:0] s1_tag;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_tag  <= '0;
         tag_out <= '0;
      end else begin
         if (adv1 && in_valid) begin
            s1_tag <= tag_in;
         end
         if (adv2 && s1_valid) begin
            tag_out <= s1_tag;
         end
      end
   end
`endif

endmodule

// File: doc/lzc_norm_pipe.md
Name: lzc_norm_pipe

Overview:
- Parametrised, pipelined leading-zero counter and normaliser for the FPU add/sub path. It is the successor to the fixed 27-bit combinational leading-one search.
- Counts leading zeros of a mantissa from a configurable top bit downward, with a configurable upper guard region excluded from the search.
- Outputs the count, a zero flag, and the left-normalised mantissa.
- Two-stage elastic pipeline with valid/ready handshakes on both sides.
- Sits between the mantissa adder and the exponent-adjust/rounding stage.

Parameters:
- WIDTH, 27, mantissa width in bits.
- MSB_IDX, 25, highest bit searched; bits WIDTH-1..MSB_IDX+1 are ignored for counting. Legal range 0..WIDTH-1.
- GROUP, 4, bits per stage-1 sub-encoder group; the searched field is split into ceil((MSB_IDX+1)/GROUP) groups, last group padded with zeros at the LSB end.
- CNT_W, $clog2(MSB_IDX+2), count width (derived; do not override).
- TAG_W, 8, width of optional sideband tag.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_data  in  WIDTH  mantissa to normalise
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_cnt  out  CNT_W  leading-zero count from bit MSB_IDX
- out_zero  out  1  bits MSB_IDX..0 all zero
- out_norm  out  WIDTH  in_data << out_cnt, truncated to WIDTH
- tag_in  in  TAG_W  sideband (only with LZN_TAG_EN)
- tag_out  out  TAG_W  sideband (only with LZN_TAG_EN)

Behaviour:
- Reset: one clock, synchronous, active-high on rst.
  - While rst=1 at a rising edge: s1_valid, s2_valid, out_valid, out_cnt, out_zero, out_norm (and tag_out) clear to 0.
  - in_ready=1 in the first cycle after reset.
  - A beat in flight during reset is discarded and never emitted.
- Count:
  - cnt = MSB_IDX - (index of highest set bit within MSB_IDX..0).
  - If none is set: cnt = MSB_IDX+1 and zero=1. With defaults, bit25 set gives 0, only bit0 set gives 25, and no bit set gives 26.
  - Bits above MSB_IDX never affect cnt.
- Normalise: norm = in_data << cnt, zero-filled and truncated to WIDTH. When zero=1, the shift is MSB_IDX+1, so all searched bits leave position.
- Stage 1 (registered): captures in_data, a per-group nonzero flag and a per-group local count (0..GROUP-1).
- Stage 2 (registered): selects the first nonzero group from the top, forms cnt = group_index*GROUP + local_cnt, and applies the barrel shift. Outputs come directly from stage-2 registers.
- Latency: exactly 2 cycles from the accepting edge (in_valid&&in_ready) to out_valid when out_ready is held 1. Throughput is one beat per cycle.
- Handshake (elastic, no bubbles under continuous flow):
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1
  - Stage registers load only when their advance is 1; otherwise they hold.
  - out_cnt, out_zero and out_norm stay stable while out_valid=1 and out_ready=0.
- Simultaneous events:
  - A new accept while stage 2 drains in the same cycle is legal; both happen.
  - in_valid=1 with in_ready=0 is not accepted; the source must hold its data.
- Full: with both stages valid and out_ready=0, in_ready=0.
- Empty: out_valid=0; output data holds its last value (don't-care).
- in_ready is combinationally dependent on out_ready (documented; no loop because out_ready must not depend on in_ready).

Optional Feature:
- Macro LZN_TAG_EN.
- Defined: tag_in is captured with in_data and travels through both stages. tag_out is aligned with out_valid, holds under stall, and resets to 0.
- Undefined: the tag_in/tag_out ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Defaults, out_ready=1, in_data=27'h2000000 then 27'h0000001 -> two cycles later, consecutive beats: cnt=0, zero=0, norm=27'h2000000; then cnt=25, zero=0, norm=27'h2000000.
- in_data=27'h4000000 (only guard bit 26 set) -> cnt=26, zero=1, norm=27'h0000000. in_data=0 -> cnt=26, zero=1, norm=0.
- in_data=27'h0012345 -> cnt=9, norm=27'h2468A00 (27'h0012345<<9 truncated to 27 bits).
- Backpressure: stream 4 beats while out_ready=0 for 3 cycles -> in_ready drops after 2 accepts, out data stable during the stall, all beats delivered in order with none dropped or duplicated.
- Assert rst with both stages valid -> next cycle out_valid=0, in_ready=1, outputs 0, and the flushed beats never appear.
- WIDTH=48, MSB_IDX=46, GROUP=8, LZN_TAG_EN defined, in_data=1 with tag 8'hA5 -> cnt=46, norm=48'h4000_0000_0000, tag_out=8'hA5.
